// File: rtl/wr_drain_ctrl_pkg.sv
// Shared definitions for the write-drain controller: FIFO entry layout, store size
// encoding and FSM state encoding.
package wr_drain_ctrl_pkg;

  localparam int unsigned DATA_LSB = 0;
  localparam int unsigned ADDR_LSB = 64;
  localparam int unsigned SIZE_LSB = 96;

  localparam logic [1:0] SizeB1 = 2'b00;
  localparam logic [1:0] SizeB2 = 2'b01;
  localparam logic [1:0] SizeB4 = 2'b10;
  localparam logic [1:0] SizeB8 = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBeat0 = 2'd1,
    StBeat1 = 2'd2
  } state_e;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    logic [3:0] n;
    unique case (size)
      SizeB1:  n = 4'd1;
      SizeB2:  n = 4'd2;
      SizeB4:  n = 4'd4;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    unique case (size)
      SizeB1:  m = 8'h01;
      SizeB2:  m = 8'h03;
      SizeB4:  m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/wr_align.sv
// Combinational lane alignment of one store: shifts data and byte mask into a
// 16-lane window and flags stores that spill into the next 8-byte word.
module wr_align
  import wr_drain_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [2:0]  addr,
  input  logic [63:0] data,
  output logic [63:0] data_lo,
  output logic [63:0] data_hi,
  output logic [7:0]  be_lo,
  output logic [7:0]  be_hi,
  output logic        split
);

  logic [127:0] data_sh;
  logic [15:0]  be_sh;
  logic [3:0]   nbytes;

  always_comb begin
    nbytes  = size_bytes(size);
    data_sh = {64'b0, data} << {addr, 3'b000};
    be_sh   = {8'b0, size_mask(size)} << addr;
    // off + n fits in 4 bits (max 7 + 8 = 15)
    split   = ({1'b0, addr} + nbytes) > 4'd8;
  end

  assign data_lo = data_sh[63:0];
  assign data_hi = data_sh[127:64];
  assign be_lo   = be_sh[7:0];
  assign be_hi   = be_sh[15:8];

endmodule

// File: rtl/wr_drain_ctrl.sv
// Write-drain controller: pops store entries from the write FIFO and issues them as
// one or two aligned 64-bit memory beats over a req/ack handshake.
module wr_drain_ctrl
  import wr_drain_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 98,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned MEM_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [MEM_W-1:0]  mem_wr_data,
  output logic [7:0]        mem_wr_be,
  input  logic              mem_wr_ack,
  output logic              wr_idle
);

  state_e state_q, state_d;

  logic [1:0]        head_size;
  logic [ADDR_W-1:0] head_addr;
  logic [63:0]       head_data;
  logic [ADDR_W-1:0] head_b0_addr;
  logic [ADDR_W-1:0] head_b1_addr;

  logic [63:0] al_data_lo, al_data_hi;
  logic [7:0]  al_be_lo, al_be_hi;
  logic        al_split;

  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [MEM_W-1:0]  data_q;
  logic [7:0]        be_q;
  logic              split_q;
  logic [ADDR_W-1:0] b1_addr_q;
  logic [MEM_W-1:0]  b1_data_q;
  logic [7:0]        b1_be_q;

  logic pop;
  logic load_b1;
  logic drop_req;

  assign head_size    = fifo_rd_data[SIZE_LSB +: 2];
  assign head_addr    = fifo_rd_data[ADDR_LSB +: ADDR_W];
  assign head_data    = fifo_rd_data[DATA_LSB +: 64];
  assign head_b0_addr = {head_addr[ADDR_W-1:3], 3'b000};
  // Modulo-2^ADDR_W add: the top aligned word wraps to address 0
  assign head_b1_addr = head_b0_addr + ADDR_W'(8);

  wr_align u_align (
    .size    (head_size),
    .addr    (head_addr[2:0]),
    .data    (head_data),
    .data_lo (al_data_lo),
    .data_hi (al_data_hi),
    .be_lo   (al_be_lo),
    .be_hi   (al_be_hi),
    .split   (al_split)
  );

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    load_b1  = 1'b0;
    drop_req = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = StBeat0;
        end
      end
      StBeat0: begin
        if (mem_wr_ack) begin
          if (split_q) begin
            load_b1 = 1'b1;
            state_d = StBeat1;
          end else if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            drop_req = 1'b1;
            state_d  = StIdle;
          end
        end
      end
      StBeat1: begin
        if (mem_wr_ack) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = StBeat0;
          end else begin
            drop_req = 1'b1;
            state_d  = StIdle;
          end
        end
      end
      default: begin
        drop_req = 1'b1;
        state_d  = StIdle;
      end
    endcase
  end

  // The FSM may sit in IDLE with a non-empty FIFO while reset is held; never pop then
  assign fifo_rd = pop & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      req_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      be_q      <= '0;
      split_q   <= 1'b0;
      b1_addr_q <= '0;
      b1_data_q <= '0;
      b1_be_q   <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        req_q     <= 1'b1;
        addr_q    <= head_b0_addr;
        data_q    <= MEM_W'(al_data_lo);
        be_q      <= al_be_lo;
        split_q   <= al_split;
        b1_addr_q <= head_b1_addr;
        b1_data_q <= MEM_W'(al_data_hi);
        b1_be_q   <= al_be_hi;
      end else if (load_b1) begin
        addr_q  <= b1_addr_q;
        data_q  <= b1_data_q;
        be_q    <= b1_be_q;
        split_q <= 1'b0;
      end else if (drop_req) begin
        req_q <= 1'b0;
      end
    end
  end

  assign mem_wr_req  = req_q;
  assign mem_wr_addr = addr_q;
  assign mem_wr_data = data_q;
  assign mem_wr_be   = be_q;
  assign wr_idle     = (state_q == StIdle) && fifo_empty;

endmodule
